led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED pattern generator. It succeeds the fixed 8-bit Johnson LED counter. A free-running timebase with selectable speed advances one of four patterns: Johnson, binary, ring and bounce. Pause, single-step and wrap/advance status are provided. It drives the board LED bank directly.

Parameters:
WIDTH, 8, number of LED outputs (legal range 2..32)
TB_BITS, 23, timebase counter width (legal range 4..32)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
mode  input  2  pattern select: 0 Johnson, 1 binary up, 2 ring, 3 bounce
speed  input  2  timebase divisor shift; higher value gives a faster tick
pause  input  1  freezes the timebase and the pattern
step  input  1  single-step request; honoured only while pause=1
q_led  output  WIDTH  registered pattern output
advance  output  1  one-cycle pulse, registered, asserted on each cycle q_led changes by a pattern step
wrap  output  1  one-cycle pulse, registered, asserted when a step returns the pattern to its seed

Behaviour:
- Reset is asynchronous and active-low. It clears tb_cnt, q_led, advance, wrap, mode_q and the bounce state (pos=0, dir=up) immediately.
- Timebase:
  - tb_cnt is TB_BITS wide and increments by 1 each clk while pause=0. It holds while pause=1. It wraps naturally.
  - mask = all-ones(TB_BITS) >> speed.
  - tick = ((tb_cnt & mask) == mask) && !pause.
  - Period is 2^(TB_BITS-speed) cycles.
- Step event: go = tick, or (pause && step). A held step advances once per cycle while it is high.
- Mode tracking:
  - mode_q registers mode every cycle.
  - reload = (mode != mode_q). This also fires the first cycle after reset if mode != 0.
  - On reload, q_led and the bounce state load the seed of the new mode.
  - Reload has priority over go. The coincident go is dropped: no step, advance=0, wrap=0.
  - tb_cnt is not affected by reload.
- Seeds:
  - Johnson: 0.
  - Binary: 0.
  - Ring: 1 (bit 0 lit).
  - Bounce: pos=0, dir=up, q_led=1.
- Step rules, applied on go without reload; q_led updates at the same clock edge:
  - Johnson: q <= {~q[0], q[WIDTH-1:1]}. Period 2*WIDTH.
  - Binary: q <= q+1 modulo 2^WIDTH. Period 2^WIDTH.
  - Ring: q <= {q[WIDTH-2:0], q[WIDTH-1]}. Period WIDTH. If q is 0 (not reachable via reload), load 1.
  - Bounce: q = 1<<pos.
    - dir=up and pos=WIDTH-1: pos <= WIDTH-2, dir <= down.
    - dir=down and pos=0: pos <= 1, dir <= up.
    - Otherwise pos moves ±1 in dir.
    - Period 2*(WIDTH-1).
- advance is set to 1 for exactly the cycle following a step edge, otherwise 0.
- wrap is set with advance when the new state equals the mode's seed. For bounce, the seed state is pos=0, dir=up.
- Reset mid-operation returns everything to reset values regardless of phase. There is no partial-state retention.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and speed: WIDTH=8, TB_BITS=4, mode=0, speed=0, release reset.
  - Required: q_led=00h; first advance at cycle 16 with q_led=80h; then C0h, E0h … FFh, 7Fh … 00h.
  - Required: wrap pulses on the 16th step.
  - With speed=2: steps every 4 cycles.
- Binary wrap: mode=1, WIDTH=4, TB_BITS=4, speed=3 (tick every 2 cycles) → q_led counts 0..F→0; wrap asserts exactly once per 16 steps, coincident with q_led=0.
- Mode change mid-run: mode=0 running at q_led=E0h; set mode=2 → the next cycle q_led=01h, with no advance even if tick coincided. Subsequent steps give 02h, 04h … 80h, 01h (wrap on 01h).
- Bounce ends: mode=3, WIDTH=4.
  - Required: sequence 1,2,4,8,4,2,1,2 …; wrap on each return to 1 moving up, every 6 steps.
  - Required: direction flips exactly at 8 and at 1.
- Pause/step: pause=1 for 100 cycles → q_led and tb_cnt are frozen, no advance. A 1-cycle step pulse → exactly one step and one advance pulse. A step with pause=0 → ignored.
- Async reset mid-step: assert reset_n=0 between clock edges while mode=3, pos=2 → q_led=0, advance=0, wrap=0 immediately. After release, the mode≠0 reload loads the bounce seed (q_led=01h).

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: Johnson, binary, ring and bounce patterns
// advanced by a speed-selectable free-running timebase.
module led_pattern_gen #(
  parameter int WIDTH   = 8,
  parameter int TB_BITS = 23
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  input  logic             step,
  output logic [WIDTH-1:0] q_led,
  output logic             advance,
  output logic             wrap
);

  localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PMAX = PW'(WIDTH - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [TB_BITS-1:0] ONES = '1;

  logic [TB_BITS-1:0] tb_cnt_q, tb_cnt_d;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   led_q, led_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               adv_q, adv_d;
  logic               wrap_q, wrap_d;

  logic [TB_BITS-1:0] mask;
  logic               tick;
  logic               go;
  logic               reload;

  assign mask   = ONES >> speed;
  assign tick   = ((tb_cnt_q & mask) == mask) && !pause;
  assign go     = tick || (pause && step);
  assign reload = (mode != mode_q);

  always_comb begin
    tb_cnt_d = pause ? tb_cnt_q : tb_cnt_q + TB_BITS'(1);
    led_d    = led_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    adv_d    = 1'b0;
    wrap_d   = 1'b0;
    if (reload) begin
      pos_d = '0;
      dir_d = 1'b0;
      unique case (mode)
        2'd0:    led_d = '0;
        2'd1:    led_d = '0;
        2'd2:    led_d = ONE;
        default: led_d = ONE;
      endcase
    end else if (go) begin
      adv_d = 1'b1;
      unique case (mode_q)
        2'd0: begin
          led_d  = {~led_q[0], led_q[WIDTH-1:1]};
          wrap_d = (led_d == '0);
        end
        2'd1: begin
          led_d  = led_q + WIDTH'(1);
          wrap_d = (led_d == '0);
        end
        2'd2: begin
          if (led_q == '0) led_d = ONE;
          else led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
          wrap_d = (led_d == ONE);
        end
        default: begin
          // dir_q: 0 moving up, 1 moving down; ends flip on departure
          if (!dir_q && pos_q == PMAX) begin
            pos_d = PMAX - PONE;
            dir_d = 1'b1;
          end else if (dir_q && pos_q == '0) begin
            pos_d = PONE;
            dir_d = 1'b0;
          end else if (dir_q) begin
            pos_d = pos_q - PONE;
          end else begin
            pos_d = pos_q + PONE;
          end
          led_d  = ONE << pos_d;
          wrap_d = (pos_d == '0);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tb_cnt_q <= '0;
      mode_q   <= '0;
      led_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      adv_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      tb_cnt_q <= tb_cnt_d;
      mode_q   <= mode;
      led_q    <= led_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      adv_q    <= adv_d;
      wrap_q   <= wrap_d;
    end
  end

  assign q_led   = led_q;
  assign advance = adv_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised bench for led_pattern_gen against a step-index
// reference model of the four patterns.
module tb_led_pattern_gen;

  localparam int W  = 8;
  localparam int TB = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   mode;
  logic [1:0]   speed;
  logic         pause;
  logic         step;
  logic [W-1:0] q_led;
  logic         advance;
  logic         wrap;

  int vectors = 0;
  int errors  = 0;

  int m_mode;
  int m_prev;
  int m_k;
  int m_tcnt;
  int e_adv;
  int e_wrap;

  led_pattern_gen #(.WIDTH(W), .TB_BITS(TB)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .speed(speed),
    .pause(pause), .step(step), .q_led(q_led),
    .advance(advance), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int period(input int m);
    case (m)
      0:       return 2 * W;
      1:       return 1 << W;
      2:       return W;
      default: return 2 * W - 2;
    endcase
  endfunction

  function automatic int exp_q(input int m, input int k);
    int r;
    int v;
    r = k % period(m);
    case (m)
      0:       v = (r <= W) ? (((1 << r) - 1) << (W - r))
                            : ((1 << (2 * W - r)) - 1);
      1:       v = r;
      2:       v = 1 << r;
      default: v = 1 << ((r < W) ? r : (2 * W - 2 - r));
    endcase
    return v & ((1 << W) - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_k = 0; m_tcnt = 0;
    e_adv = 0; e_wrap = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, 32'(q_led), 32'(exp_q(m_mode, m_k)));
    chk({tag, ".adv"}, 32'(advance), 32'(e_adv));
    chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  task automatic cycle(input string tag);
    bit tick;
    bit go;
    @(posedge clk);
    tick = (((m_tcnt + 1) % (1 << (TB - int'(speed)))) == 0) && !pause;
    go   = tick || (pause && step);
    if (int'(mode) != m_prev) begin
      m_mode = int'(mode); m_k = 0; e_adv = 0; e_wrap = 0;
    end else if (go) begin
      m_k++;
      e_adv  = 1;
      e_wrap = (m_k % period(m_mode) == 0) ? 1 : 0;
    end else begin
      e_adv = 0; e_wrap = 0;
    end
    if (!pause) m_tcnt = (m_tcnt + 1) % (1 << TB);
    m_prev = int'(mode);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic run_until(input string tag, input int m, input int kk,
                           input int bound);
    int n = 0;
    while (!(m_mode == m && (m_k % period(m)) == kk) && n < bound) begin
      cycle(tag);
      n++;
    end
    if (n >= bound) chk({tag, ".timeout"}, 32'(0), 32'(1));
  endtask

  task automatic async_reset(input string tag);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".q"}, 32'(q_led), 32'(0));
    chk({tag, ".adv"}, 32'(advance), 32'(0));
    chk({tag, ".wrap"}, 32'(wrap), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    mode = 2'd0; speed = 2'd0; pause = 1'b0; step = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    run("johnson", 40);
    speed = 2'd2;
    run("speed2", 40);

    mode = 2'd1; speed = 2'd3;
    run("binary", 520);

    mode = 2'd0; speed = 2'd0;
    run_until("find_e0", 0, 3, 300);
    chk("at_e0", 32'(q_led), 32'h0e0);
    mode = 2'd2;
    run("ring", 60);

    mode = 2'd3; speed = 2'd3;
    run("bounce", 60);

    pause = 1'b1;
    run("paused", 100);
    step = 1'b1;
    cycle("step1");
    step = 1'b0;
    run("paused2", 5);
    pause = 1'b0; step = 1'b1;
    run("step_np", 3);
    step = 1'b0;

    run_until("find_pos2", 3, 2, 300);
    chk("at_pos2", 32'(q_led), 32'h4);
    async_reset("areset");
    run("after_rst", 20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) mode = 2'($urandom);
      if ($urandom_range(31) == 0) speed = 2'($urandom);
      if ($urandom_range(39) == 0) pause = ~pause;
      step = ($urandom_range(3) == 0);
      if ($urandom_range(999) == 0) async_reset("rnd_rst");
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
